mac_dot_sequencer: RTL and testbench

Control stage directly upstream of `mac_unit_basic`: accepts a vector length and a valid/ready stream of (data, weight) pairs, drives the MAC's `enable`/`clear_accum`/operand ports, and captures the finished dot product from the MAC's `accum_out`. It presents each result on a valid/ready output port. This lets the datapath issue whole dot products instead of hand-sequencing `clear_accum`.

---
 rtl/mac_dot_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Control stage in front of mac_unit_basic. Accepts a vector length on a
//   start pulse, streams (data, weight) pairs into the MAC with valid/ready
//   handshaking, clears the MAC accumulator on the first element, captures the
//   finished dot product from the MAC and offers it on a valid/ready port.
//
//   Optional build macro: MAC_SEQ_SKIP_ZERO_EN
//     When defined, non-first beats carrying a zero activation or zero weight
//     are consumed without enabling the MAC (same result, less toggling).
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, cfg_len, busy  job control: start pulse, element count, busy flag
//   in_valid/in_ready     operand stream handshake
//   in_data, in_weight    operand pair
//   mac_enable, mac_clear_accum, mac_data, mac_weight   drive to MAC
//   mac_accum             accumulator value from MAC
//   res_valid/res_ready   result handshake
//   res_data              captured dot product (two's complement)

module mac_dot_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic        [LEN_WIDTH-1:0]    cfg_len,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  input  logic signed [WEIGHT_WIDTH-1:0] in_weight,
  output logic                           mac_enable,
  output logic                           mac_clear_accum,
  output logic signed [DATA_WIDTH-1:0]   mac_data,
  output logic signed [WEIGHT_WIDTH-1:0] mac_weight,
  input  logic signed [ACCUM_WIDTH-1:0]  mac_accum,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [ACCUM_WIDTH-1:0]  res_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;

  logic beat;
  logic first_beat;
  logic last_beat;
  logic skip_beat;

  assign beat       = (state == RUN) && in_valid;
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == (len_q - LEN_ONE));

`ifdef MAC_SEQ_SKIP_ZERO_EN
  // Zero operands contribute nothing; the first beat must still fire to clear.
  assign skip_beat = !first_beat && ((in_data == '0) || (in_weight == '0));
`else
  assign skip_beat = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (cfg_len == '0) ? OUT : RUN;
        end
      end
      RUN: begin
        if (beat && last_beat) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = OUT;
      end
      OUT: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic; operands are forced to zero whenever the MAC is idle
  always_comb begin
    busy            = (state != IDLE);
    in_ready        = 1'b0;
    mac_enable      = 1'b0;
    mac_clear_accum = 1'b0;
    mac_data        = '0;
    mac_weight      = '0;
    res_valid       = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        if (beat && !skip_beat) begin
          mac_enable      = 1'b1;
          mac_clear_accum = first_beat;
          mac_data        = in_data;
          mac_weight      = in_weight;
        end
      end
      OUT: begin
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Job bookkeeping and result capture; the MAC sum is final during DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= cfg_len;
            cnt   <= '0;
            if (cfg_len == '0) begin
              res_data <= '0;
            end
          end
        end
        RUN: begin
          if (beat) begin
            cnt <= cnt + LEN_ONE;
          end
        end
        DRAIN: begin
          res_data <= mac_accum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic        [7:0]  cfg_len;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic signed [7:0]  in_weight;
  logic               mac_enable;
  logic               mac_clear_accum;
  logic signed [15:0] mac_data;
  logic signed [7:0]  mac_weight;
  logic signed [31:0] mac_accum;
  logic               res_valid;
  logic               res_ready;
  logic signed [31:0] res_data;

  always #5 clk = ~clk;

  mac_dot_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .mac_enable(mac_enable), .mac_clear_accum(mac_clear_accum),
    .mac_data(mac_data), .mac_weight(mac_weight), .mac_accum(mac_accum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // Behavioural mac_unit_basic: clear loads the product, enable accumulates.
  logic signed [31:0] dx, wx, prod;
  assign dx   = mac_data;
  assign wx   = mac_weight;
  assign prod = dx * wx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_accum <= '0;
    else if (mac_enable) mac_accum <= mac_clear_accum ? prod : mac_accum + prod;
  end

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int clr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operand pass-through and enable/clear activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (mac_enable) begin
      en_cnt++;
      if (mac_clear_accum) clr_cnt++;
      chk("passthru_data", 32'(mac_data), 32'(in_data));
      chk("passthru_weight", 32'(mac_weight), 32'(in_weight));
    end else begin
      chk("idle_operands", {8'h0, mac_clear_accum, 7'h0, mac_data}, 32'h0);
      chk("idle_weight", 32'(mac_weight), 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int                 len;
    logic signed [15:0] d [4];
    logic signed [7:0]  w [4];
    logic signed [31:0] exp;
    int                 exp_en;
    string              name;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

`ifdef MAC_SEQ_SKIP_ZERO_EN
  localparam int ZERO_VEC_EN = 2;
`else
  localparam int ZERO_VEC_EN = 3;
`endif

  task automatic set_vec(input int i, input int len,
                         input int d0, input int d1, input int d2, input int d3,
                         input int w0, input int w1, input int w2, input int w3,
                         input int exp, input int exp_en, input string name);
    vecs[i].len = len;
    vecs[i].d[0] = 16'(d0); vecs[i].d[1] = 16'(d1); vecs[i].d[2] = 16'(d2); vecs[i].d[3] = 16'(d3);
    vecs[i].w[0] = 8'(w0);  vecs[i].w[1] = 8'(w1);  vecs[i].w[2] = 8'(w2);  vecs[i].w[3] = 8'(w3);
    vecs[i].exp = 32'(exp);
    vecs[i].exp_en = exp_en;
    vecs[i].name = name;
  endtask

  task automatic run_vec(input int idx);
    int lat;
    int len;
    len = vecs[idx].len;
    en_cnt = 0;
    clr_cnt = 0;
    cfg_len = 8'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({vecs[idx].name, "_busy"}, 32'(busy), 32'h1);
    if (len == 0) begin
      chk({vecs[idx].name, "_rv_next"}, 32'(res_valid), 32'h1);
      chk({vecs[idx].name, "_inrdy"}, 32'(in_ready), 32'h0);
    end else begin
      for (int i = 0; i < len; i++) begin
        in_valid = 1'b1;
        in_data = vecs[idx].d[i];
        in_weight = vecs[idx].w[i];
        chk({vecs[idx].name, "_inrdy"}, 32'(in_ready), 32'h1);
        step();
      end
      in_valid = 1'b0;
      in_data = '0;
      in_weight = '0;
      lat = len;
      while (!res_valid && lat < 40) begin
        step();
        lat++;
      end
      chk({vecs[idx].name, "_latency"}, 32'(lat), 32'(len + 1));
    end
    chk({vecs[idx].name, "_res"}, res_data, vecs[idx].exp);
    chk({vecs[idx].name, "_en_cnt"}, 32'(en_cnt), 32'(vecs[idx].exp_en));
    chk({vecs[idx].name, "_clr_cnt"}, 32'(clr_cnt), (len > 0) ? 32'h1 : 32'h0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({vecs[idx].name, "_rv_drop"}, 32'(res_valid), 32'h0);
    chk({vecs[idx].name, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int lat;
    logic signed [15:0] sd [4];
    logic signed [7:0]  sw [4];

    set_vec(0, 3, 5, 2, 10, 0, 3, 4, 2, 0, 43, 3, "len3");
    set_vec(1, 1, 6, 0, 0, 0, -2, 0, 0, 0, -12, 1, "len1_neg");
    set_vec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "len0");
    set_vec(3, 3, 0, 3, 4, 0, 5, 0, 2, 0, 8, ZERO_VEC_EN, "zero_ops");
    set_vec(4, 4, -32768, 32767, -1, -32768, -128, 127, -1, 127, 4194178, 4, "extremes");
    set_vec(5, 2, 7, 1, 0, 0, 1, 1, 0, 0, 8, 2, "post_reset");

    rst_n = 1'b0; start = 1'b0; cfg_len = '0; in_valid = 1'b1;
    in_data = 16'sd9; in_weight = 8'sd9; res_ready = 1'b0;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_mac_enable", 32'(mac_enable), 32'h0);
    in_valid = 1'b0; in_data = '0; in_weight = '0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV - 1; i++) run_vec(i);

    // len=4 with 2-cycle gaps, a start pulse in RUN and in OUT, res_ready held off
    sd[0] = 1; sd[1] = 2; sd[2] = 3; sd[3] = -4;
    sw[0] = 1; sw[1] = 2; sw[2] = 3; sw[3] = 5;
    en_cnt = 0; clr_cnt = 0;
    cfg_len = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = sd[i]; in_weight = sw[i];
      chk("stall_inrdy", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0; in_data = '0; in_weight = '0;
      if (i < 3) begin
        if (i == 1) begin
          cfg_len = 8'd1; start = 1'b1;
        end
        step();
        start = 1'b0;
        chk("stall_gap_busy", 32'(busy), 32'h1);
        step();
      end
    end
    lat = 0;
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("stall_drain", 32'(lat), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold_valid", 32'(res_valid), 32'h1);
      chk("stall_hold_data", res_data, 32'hFFFF_FFFA);
      start = (k == 2);
      cfg_len = 8'd2;
      step();
    end
    start = 1'b0;
    chk("stall_en_cnt", 32'(en_cnt), 32'h4);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("stall_rv_drop", 32'(res_valid), 32'h0);
    chk("stall_idle", 32'(busy), 32'h0);
    step();
    chk("stall_no_requeue", 32'(busy), 32'h0);

    // Reset after 2 of 4 beats, with a third pair on the bus
    cfg_len = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'sd3; in_weight = 8'sd3;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    chk("midrst_mac_enable", 32'(mac_enable), 32'h0);
    chk("midrst_mac_data", 32'(mac_data), 32'h0);
    chk("midrst_res_valid", 32'(res_valid), 32'h0);
    chk("midrst_res_data", res_data, 32'h0);
    in_valid = 1'b0; in_data = '0; in_weight = '0;
    step();
    rst_n = 1'b1;
    step();
    run_vec(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
